// File: rtl/input_module.sv
// Decimal keypad entry: accumulates BCD digits into a 32-bit binary value and hands it off with a valid/ack pair.
// Optional signed entry is enabled by defining INPUT_MODULE_SIGN_EN, which adds the neg_key port.
module input_module #(
    parameter int MAX_DIGITS = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  digit_in,
    input  logic        digit_valid,
    input  logic        enter,
    input  logic        clear,
    input  logic        value_ack,
`ifdef INPUT_MODULE_SIGN_EN
    input  logic        neg_key,
`endif
    output logic        ready,
    output logic [31:0] value_out,
    output logic        value_valid,
    output logic        overflow,
    output logic [3:0]  digit_count
);

    typedef enum logic [1:0] {EMPTY, ENTRY, DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] acc_q, acc_d;
    logic [31:0] value_q, value_d;
    logic        valid_q, valid_d;
    logic        ovf_q, ovf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        neg_q, neg_d;

    logic [35:0] prod;
    logic [35:0] limit;
    logic [31:0] commit_val;
    logic        commit_over;
    logic        digit_ok;

    assign ready       = (state_q != DONE);
    assign value_out   = value_q;
    assign value_valid = valid_q;
    assign overflow    = ovf_q;
    assign digit_count = cnt_q;

    // acc*10 + digit without a multiplier; 36 bits so the overflow test never wraps
    assign prod     = ({4'b0, acc_q} << 3) + ({4'b0, acc_q} << 1) + {32'b0, digit_in};
    assign digit_ok = (digit_in <= 4'd9);

`ifdef INPUT_MODULE_SIGN_EN
    assign limit       = neg_q ? 36'h0_8000_0000 : 36'h0_7FFF_FFFF;
    // the sign can flip after digits were taken, so re-check the range on commit
    assign commit_over = ({4'b0, acc_q} > limit);
    assign commit_val  = neg_q ? (32'd0 - acc_q) : acc_q;
`else
    assign limit       = 36'h0_FFFF_FFFF;
    assign commit_over = 1'b0;
    assign commit_val  = acc_q;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        value_d = value_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;

        if (ready) begin
            if (clear) begin
                state_d = EMPTY;
                acc_d   = 32'd0;
                cnt_d   = 4'd0;
                ovf_d   = 1'b0;
                neg_d   = 1'b0;
            end else if (enter) begin
                value_d = commit_val;
                valid_d = 1'b1;
                ovf_d   = ovf_q | commit_over;
                state_d = DONE;
            end else if (digit_valid && digit_ok) begin
                if (int'(cnt_q) >= MAX_DIGITS || prod > limit) begin
                    ovf_d = 1'b1;
                end else begin
                    acc_d   = prod[31:0];
                    cnt_d   = cnt_q + 4'd1;
                    state_d = ENTRY;
                end
            end
`ifdef INPUT_MODULE_SIGN_EN
            if (!clear && !enter && neg_key)
                neg_d = ~neg_q;
`endif
        end else if (value_ack) begin
            state_d = EMPTY;
            acc_d   = 32'd0;
            cnt_d   = 4'd0;
            valid_d = 1'b0;
            ovf_d   = 1'b0;
            neg_d   = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= EMPTY;
            acc_q   <= 32'd0;
            value_q <= 32'd0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= 4'd0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            value_q <= value_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

endmodule

// File: tb/tb_input_module.sv
// Directed bench for input_module: digit entry, limits, strobe priority, handshake and reset.
module tb_input_module;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  digit_in = 4'd0;
    logic        digit_valid = 1'b0;
    logic        enter = 1'b0;
    logic        clear = 1'b0;
    logic        value_ack = 1'b0;
`ifdef INPUT_MODULE_SIGN_EN
    logic        neg_key = 1'b0;
`endif
    logic        ready;
    logic [31:0] value_out;
    logic        value_valid;
    logic        overflow;
    logic [3:0]  digit_count;

    int checks = 0;
    int errors = 0;

    input_module #(.MAX_DIGITS(10)) dut (
        .clock       (clock),
        .reset       (reset),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .enter       (enter),
        .clear       (clear),
        .value_ack   (value_ack),
`ifdef INPUT_MODULE_SIGN_EN
        .neg_key     (neg_key),
`endif
        .ready       (ready),
        .value_out   (value_out),
        .value_valid (value_valid),
        .overflow    (overflow),
        .digit_count (digit_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // inputs change 1ns after the rising edge, outputs are sampled there too
    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit_in = d; digit_valid = 1'b1;
        cyc();
        digit_valid = 1'b0;
    endtask

    task automatic keys(input string s);
        for (int i = 0; i < s.len(); i++) begin
            logic [7:0] c;
            c = s[i];
            key(4'(c - 8'd48));
        end
    endtask

    task automatic press_enter();
        enter = 1'b1; cyc(); enter = 1'b0;
    endtask

    task automatic ack();
        value_ack = 1'b1; cyc(); value_ack = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        cyc(); cyc();
        reset = 1'b1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_value", value_out, 32'd0);
        chk("rst_valid", 32'(value_valid), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_cnt", 32'(digit_count), 32'd0);

        // basic 123
        key(4'd1);
        chk("cnt_after_1", 32'(digit_count), 32'd1);
        keys("23");
        chk("cnt_123", 32'(digit_count), 32'd3);
        press_enter();
        chk("val_123", value_out, 32'd123);
        chk("valid_123", 32'(value_valid), 32'd1);
        chk("ready_done", 32'(ready), 32'd0);
        cyc();
        chk("valid_hold", 32'(value_valid), 32'd1);
        chk("cnt_done", 32'(digit_count), 32'd3);
        value_ack = 1'b1; cyc(); value_ack = 1'b0;
        chk("valid_acked", 32'(value_valid), 32'd0);
        chk("cnt_acked", 32'(digit_count), 32'd0);
        chk("ready_acked", 32'(ready), 32'd1);

`ifndef INPUT_MODULE_SIGN_EN
        // full 32-bit range, then one past it
        keys("4294967295");
        press_enter();
        chk("val_max", value_out, 32'hFFFF_FFFF);
        chk("ovf_max", 32'(overflow), 32'd0);
        ack();
        keys("4294967296");
        chk("ovf_live", 32'(overflow), 32'd1);
        chk("cnt_ovf", 32'(digit_count), 32'd9);
        press_enter();
        chk("val_trunc", value_out, 32'd429496729);
        chk("ovf_commit", 32'(overflow), 32'd1);
        ack();
        chk("ovf_acked", 32'(overflow), 32'd0);
`endif

        // digit-count limit with leading zeros
        keys("00000000000");
        chk("cnt_max", 32'(digit_count), 32'd10);
        chk("ovf_cnt", 32'(overflow), 32'd1);
        clear = 1'b1; cyc(); clear = 1'b0;
        chk("clr_cnt", 32'(digit_count), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);

        // clear beats enter
        key(4'd5);
        clear = 1'b1; enter = 1'b1; cyc(); clear = 1'b0; enter = 1'b0;
        chk("clr_pri_valid", 32'(value_valid), 32'd0);
        chk("clr_pri_ready", 32'(ready), 32'd1);
        chk("clr_pri_cnt", 32'(digit_count), 32'd0);
        key(4'd9);
        press_enter();
        chk("val_9", value_out, 32'd9);
        ack();
        // enter in EMPTY commits 0
        press_enter();
        chk("val_empty", value_out, 32'd0);
        chk("valid_empty", 32'(value_valid), 32'd1);
        ack();

        // bad BCD ignored
        key(4'd12);
        chk("bad_cnt", 32'(digit_count), 32'd0);
        chk("bad_ovf", 32'(overflow), 32'd0);
        key(4'd8);
        // ack outside DONE ignored
        ack();
        chk("ack_entry_cnt", 32'(digit_count), 32'd1);
        press_enter();
        digit_in = 4'd5; digit_valid = 1'b1; enter = 1'b1; cyc();
        digit_valid = 1'b0; enter = 1'b0;
        chk("done_val", value_out, 32'd8);
        chk("done_cnt", 32'(digit_count), 32'd1);
        ack();

        // enter beats digit
        key(4'd4);
        digit_in = 4'd6; digit_valid = 1'b1; enter = 1'b1; cyc();
        digit_valid = 1'b0; enter = 1'b0;
        chk("ent_pri_val", value_out, 32'd4);
        ack();

        // reset while DONE, with a strobe during reset
        keys("77");
        press_enter();
        chk("val_77", value_out, 32'd77);
        reset = 1'b0; digit_in = 4'd3; digit_valid = 1'b1;
        cyc();
        reset = 1'b1; digit_valid = 1'b0;
        chk("rst_done_val", value_out, 32'd0);
        chk("rst_done_valid", 32'(value_valid), 32'd0);
        chk("rst_done_ready", 32'(ready), 32'd1);
        chk("rst_done_cnt", 32'(digit_count), 32'd0);

`ifdef INPUT_MODULE_SIGN_EN
        neg_key = 1'b1; cyc(); neg_key = 1'b0;
        keys("2147483648");
        press_enter();
        chk("neg_min", value_out, 32'h8000_0000);
        chk("neg_ovf", 32'(overflow), 32'd0);
        ack();
        keys("2147483648");
        chk("pos_ovf", 32'(overflow), 32'd1);
        press_enter();
        chk("pos_val", value_out, 32'd214748364);
        ack();
        keys("12");
        neg_key = 1'b1; cyc(); neg_key = 1'b0;
        press_enter();
        chk("neg_12", value_out, 32'hFFFF_FFF4);
        ack();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/input_module.md
INPUT_MODULE -- requirements
Module: input_module

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 10: max decimal digits accepted per entry.
REQ-002 SHALL have port clock  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port digit_in  input  4  BCD digit from keypad/switches.
REQ-005 SHALL have port digit_valid  input  1  one-cycle strobe qualifying digit_in.
REQ-006 SHALL have port enter  input  1  one-cycle strobe committing the entry.
REQ-007 SHALL have port clear  input  1  one-cycle strobe discarding the entry.
REQ-008 SHALL have port value_ack  input  1  consumer acknowledge of value_out.
REQ-009 SHALL have port ready  output  1  high when digits/enter are accepted.
REQ-010 SHALL have port value_out  output  32  committed binary value.
REQ-011 SHALL have port value_valid  output  1  value_out valid, held until acknowledged.
REQ-012 SHALL have port overflow  output  1  sticky error flag for current/committed entry.
REQ-013 SHALL have port digit_count  output  4  digits accepted in current entry.

Function
REQ-014 SHALL implement FSM states EMPTY, ENTRY, DONE; ready=1 in EMPTY/ENTRY, 0 in DONE.
REQ-015 SHALL, on accepted digit (digit_valid, ready, digit_in<=9), set acc <= acc*10 + digit_in via (acc<<3)+(acc<<1)+digit, visible one cycle later; EMPTY->ENTRY.
REQ-016 SHALL ignore digit_in values 10-15 with no state change.
REQ-017 SHALL, when acc*10+digit exceeds the magnitude limit (unsigned 2^32-1), discard the digit, keep acc, set overflow.
REQ-018 SHALL, when digit_count==MAX_DIGITS, discard further digits and set overflow.
REQ-019 SHALL, on enter with ready, load value_out<=acc, assert value_valid next cycle, go DONE; enter in EMPTY commits 0.
REQ-020 SHALL hold value_out, value_valid, overflow stable in DONE until value_ack; value_ack in DONE -> EMPTY next cycle with acc=0, digit_count=0, value_valid=0, overflow=0.
REQ-021 SHALL ignore digit_valid and enter in DONE; value_ack outside DONE SHALL be ignored.
REQ-022 SHALL, on clear in EMPTY/ENTRY, zero acc, digit_count, overflow and go EMPTY; clear in DONE ignored.
REQ-023 SHALL resolve simultaneous strobes by priority clear > enter > digit_valid; lower-priority strobes that cycle are dropped.
REQ-024 SHALL count leading zeros in digit_count; value_out unaffected by them.

Reset
REQ-025 SHALL, with reset=0 at a clock edge, force state EMPTY, acc=0, value_out=0, value_valid=0, overflow=0, digit_count=0, ready=1 next cycle, including mid-entry or in DONE.
REQ-026 SHALL ignore all strobes during cycles where reset=0.

Configuration
REQ-027 SHALL support macro INPUT_MODULE_SIGN_EN; when defined, adds port neg_key input 1 toggling a sign flag while ready, cleared by clear/ack/reset.
REQ-028 SHALL, with INPUT_MODULE_SIGN_EN defined, use magnitude limit 2^31 (negative) or 2^31-1 (positive), evaluated at enter as well; commit of out-of-range magnitude sets overflow and value_out=acc's two's-complement truncation; negative commit outputs -acc.
REQ-029 SHALL, without INPUT_MODULE_SIGN_EN, have no neg_key port and treat all entries as unsigned.

Verification
REQ-030 SHALL cover: digits 1,2,3 then enter -> value_out=123, value_valid=1 until ack, digit_count=3.
REQ-031 SHALL cover: digits 4,2,9,4,9,6,7,2,9,5 enter -> value_out=4294967295, overflow=0; repeat ending 6 -> last digit dropped, value_out=429496729, overflow=1.
REQ-032 SHALL cover: digit 5, then clear and enter same cycle -> EMPTY, no value_valid.
REQ-033 SHALL cover: reset=0 while DONE with value_out=77 -> value_out=0, value_valid=0, ready=1 next cycle.
REQ-034 SHALL cover: digit_in=12 strobed -> ignored; digits in DONE -> ignored; enter in EMPTY -> value_out=0.
REQ-035 SHALL cover (INPUT_MODULE_SIGN_EN): neg_key, digits 2147483648, enter -> value_out=0x80000000, overflow=0; positive same -> overflow=1.
